// File: rtl/nn_pkg.sv
// Shared definitions for the dense-layer sequencers: datapath widths,
// default accumulator/quantizer sizes, FSM encodings and the quantizer.
package nn_pkg;

  localparam int ACT_W     = 8;
  localparam int W_W       = 8;
  localparam int B_W       = 16;
  localparam int ACC_W_DEF = 23;
  localparam int FRAC_DEF  = 6;
  // Widest accumulator the quantize function accepts.
  localparam int Q_MAX_W   = 64;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC   = 3'd1,
    S_QUANT = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // ReLU + round-half-up + saturate to 0..127. The accumulator arrives
  // zero-extended to Q_MAX_W bits; acc_w tells where its sign bit sits.
  // Bit frac+7 is part of the overflow test, so the rounded field can only
  // reach 128 from 127 + round bit, which is clamped back to 127.
  function automatic logic [ACT_W-1:0] q(input logic [Q_MAX_W-1:0] s,
                                         input int acc_w,
                                         input int frac);
    logic [Q_MAX_W-1:0] body;
    logic [Q_MAX_W-1:0] high;
    logic [ACT_W-1:0]   mag;
    logic               rnd;
    logic [ACT_W:0]     sum;
    body = s & ((64'd1 << (acc_w - 1)) - 64'd1);
    high = body >> (frac + ACT_W - 1);
    mag  = ACT_W'(s >> frac);
    if (frac > 0) begin
      rnd = 1'(s >> (frac - 1));
    end else begin
      rnd = 1'b0;
    end
    sum = {1'b0, mag} + {{ACT_W{1'b0}}, rnd};
    if (1'(s >> (acc_w - 1)) == 1'b1) begin
      q = 8'd0;
    end else if (high != 64'd0) begin
      q = 8'd127;
    end else if (sum > 9'd127) begin
      q = 8'd127;
    end else begin
      q = sum[ACT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/nn_quant.sv
// Combinational layer quantizer: signed accumulator in, 8-bit activation out.
// Shared by every layer sequencer that uses the common fixed-point format.
module nn_quant
  import nn_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic [ACC_W-1:0] acc,
  output logic [7:0]       q_out
);

  logic [Q_MAX_W-1:0] acc_ext_s;

  // Widen the accumulator and apply the shared quantize function.
  always_comb begin
    acc_ext_s            = '0;
    acc_ext_s[ACC_W-1:0] = acc;
    q_out                = q(acc_ext_s, ACC_W, FRAC);
  end

endmodule

// File: rtl/layer_sequencer.sv
// Dense-layer sequencer: one signed 8x8 MAC shared across all OUT_N neurons.
// Each neuron reads IN_N weights and a bias, accumulates, quantizes and
// hands one activation downstream over a valid/ready handshake.
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int IN_N  = 15,
  parameter int OUT_N = 32,
  parameter int ACC_W = ACC_W_DEF,
  parameter int FRAC  = FRAC_DEF,
  localparam int WA_W = (IN_N * OUT_N > 1) ? $clog2(IN_N * OUT_N) : 1,
  localparam int BA_W = (OUT_N > 1) ? $clog2(OUT_N) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_N*ACT_W-1:0] in_act,
  output logic                  busy,
  output logic                  w_rd_en,
  output logic [WA_W-1:0]       w_addr,
  input  logic [W_W-1:0]        w_data,
  output logic                  b_rd_en,
  output logic [BA_W-1:0]       b_addr,
  input  logic [B_W-1:0]        b_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACT_W-1:0]      out_data,
  output logic [BA_W-1:0]       out_idx,
  output logic                  done
);

  localparam int KW = $clog2(IN_N + 1);

  state_t                  state_r;
  // Latched activations; rotated one element per MAC so element k-1 is
  // always in the low byte, and back in original order after IN_N steps.
  logic [IN_N*ACT_W-1:0]   act_r;
  logic [ACC_W-1:0]        acc_r;
  logic [KW-1:0]           k_r;
  logic [BA_W-1:0]         neuron_r;

  logic signed [15:0]      prod_s;
  logic [ACC_W-1:0]        acc_base_s;
  logic [ACC_W-1:0]        acc_next_s;
  logic [KW-1:0]           k_next_s;
  logic                    rd_more_s;
  logic [ACT_W-1:0]        q_s;

  nn_quant #(
    .ACC_W (ACC_W),
    .FRAC  (FRAC)
  ) u_quant (
    .acc   (acc_r),
    .q_out (q_s)
  );

  // MAC: product of current activation and returning weight, seeded with the bias on step 1.
  always_comb begin
    prod_s = 16'($signed(act_r[ACT_W-1:0])) * 16'($signed(w_data));
    if (k_r == KW'(1'b1)) begin
      acc_base_s = ACC_W'($signed(b_data));
    end else begin
      acc_base_s = acc_r;
    end
    acc_next_s = acc_base_s + ACC_W'(prod_s);
    k_next_s   = k_r + KW'(1'b1);
    rd_more_s  = (k_next_s < KW'(IN_N));
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      act_r     <= '0;
      acc_r     <= '0;
      k_r       <= '0;
      neuron_r  <= '0;
      busy      <= 1'b0;
      w_rd_en   <= 1'b0;
      w_addr    <= '0;
      b_rd_en   <= 1'b0;
      b_addr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      done      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            act_r    <= in_act;
            neuron_r <= '0;
            k_r      <= '0;
            busy     <= 1'b1;
            w_rd_en  <= 1'b1;
            w_addr   <= '0;
            b_rd_en  <= 1'b1;
            b_addr   <= '0;
            state_r  <= S_ACC;
          end
        end
        S_ACC: begin
          b_rd_en <= 1'b0;
          if (k_r != '0) begin
            acc_r <= acc_next_s;
            act_r <= (IN_N*ACT_W)'({act_r[ACT_W-1:0], act_r} >> ACT_W);
          end
          if (k_r == KW'(IN_N)) begin
            k_r     <= '0;
            w_rd_en <= 1'b0;
            state_r <= S_QUANT;
          end else begin
            k_r     <= k_next_s;
            w_rd_en <= rd_more_s;
            if (rd_more_s) begin
              w_addr <= w_addr + WA_W'(1'b1);
            end
          end
        end
        S_QUANT: begin
          out_data  <= q_s;
          out_idx   <= neuron_r;
          out_valid <= 1'b1;
          state_r   <= S_EMIT;
        end
        S_EMIT: begin
          // Everything holds while stalled; no memory reads are issued.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (neuron_r == BA_W'(OUT_N - 1)) begin
              done    <= 1'b1;
              state_r <= S_DONE;
            end else begin
              neuron_r <= neuron_r + BA_W'(1'b1);
              b_addr   <= neuron_r + BA_W'(1'b1);
              b_rd_en  <= 1'b1;
              w_rd_en  <= 1'b1;
              w_addr   <= w_addr + WA_W'(1'b1);
              k_r      <= '0;
              state_r  <= S_ACC;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          w_rd_en   <= 1'b0;
          b_rd_en   <= 1'b0;
          out_valid <= 1'b0;
          done      <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: memory models answer reads, expected
// activations are pushed per run and popped on each output handshake.
module tb_layer_sequencer;

  localparam int IN_N  = 15;
  localparam int OUT_N = 32;
  localparam int WA_W  = 9;
  localparam int BA_W  = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [IN_N*8-1:0]   in_act;
  logic                busy;
  logic                w_rd_en;
  logic [WA_W-1:0]     w_addr;
  logic [7:0]          w_data;
  logic                b_rd_en;
  logic [BA_W-1:0]     b_addr;
  logic [15:0]         b_data;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          out_data;
  logic [BA_W-1:0]     out_idx;
  logic                done;

  logic signed [7:0]   wmem [IN_N*OUT_N];
  logic signed [15:0]  bmem [OUT_N];
  logic signed [7:0]   acts [IN_N];

  int                  checks = 0;
  int                  errors = 0;
  logic [15:0]         exp_q [$];
  int                  res_cnt;
  int                  done_cnt;
  int                  first_valid;
  int                  done_cyc;

  layer_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_act    (in_act),
    .busy      (busy),
    .w_rd_en   (w_rd_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .b_rd_en   (b_rd_en),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous weight and bias memories, one cycle read latency.
  always @(posedge clk) begin
    if (w_rd_en) w_data <= wmem[w_addr];
    if (b_rd_en) b_data <= bmem[b_addr];
  end

  // Reference quantizer: negative -> 0, else round(sum/64) clamped to 127.
  function automatic logic [7:0] model_q(input longint s);
    longint v;
    if (s < 0) return 8'd0;
    v = (s + 32) / 64;
    if (v > 127) return 8'd127;
    return 8'(v);
  endfunction

  task automatic push_expected();
    longint sum;
    for (int n = 0; n < OUT_N; n++) begin
      sum = longint'(bmem[n]);
      for (int i = 0; i < IN_N; i++)
        sum += longint'(acts[i]) * longint'(wmem[n*IN_N+i]);
      exp_q.push_back({8'(n), model_q(sum)});
    end
  endtask

  task automatic pack_acts();
    for (int i = 0; i < IN_N; i++) in_act[8*i +: 8] = acts[i];
  endtask

  // One full layer run: start, accept results, optional stall and stray starts.
  task automatic run_layer(input int stall_idx, input int stall_len,
                           input bit poke, input int post);
    int          stall_left;
    logic [7:0]  held_d;
    logic [15:0] e;
    bit          seen_done;
    int          post_left;
    res_cnt = 0; done_cnt = 0; first_valid = -1; done_cyc = -1;
    stall_left = stall_len; seen_done = 1'b0; post_left = post; held_d = 8'd0;
    push_expected();
    @(negedge clk);
    pack_acts();
    start = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 4) in_act = {4{$urandom}};
      if (poke && cyc == 6) start = 1'b1;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_idx == 5'(stall_idx) && stall_left > 0) begin
        if (stall_left < stall_len) begin
          checks++;
          if (out_data !== held_d || w_rd_en !== 1'b0 || b_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold data=%0d want %0d w_rd_en=%b b_rd_en=%b want 0",
                     out_data, held_d, w_rd_en, b_rd_en);
          end
        end else begin
          held_d = out_data;
        end
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        res_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_result idx=%0d data=%0d want none", out_idx, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e[7:0] || {3'b000, out_idx} !== e[15:8]) begin
            errors++;
            $display("FAIL result idx=%0d data=%0d want idx=%0d data=%0d",
                     out_idx, out_data, e[15:8], e[7:0]);
          end
        end
      end
      if (done) begin
        done_cnt++;
        if (!seen_done) done_cyc = cyc;
        seen_done = 1'b1;
        if (poke) start = 1'b1;
      end
      if (seen_done) begin
        if (post_left == 0) break;
        post_left--;
      end
    end
    out_ready = 1'b1;
    if (!seen_done) begin
      checks++; errors++;
      $display("FAIL run_timeout results=%0d want %0d", res_cnt, OUT_N);
      exp_q.delete();
    end
  endtask

  task automatic end_of_run_checks(input string tag);
    checks++;
    if (res_cnt !== OUT_N || done_cnt !== 1 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_counts results=%0d done=%0d left=%0d want %0d 1 0",
               tag, res_cnt, done_cnt, exp_q.size(), OUT_N);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; out_ready = 1'b1; in_act = '0;
    w_data = 8'd0; b_data = 16'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, w_rd_en, b_rd_en, out_valid, done, out_data, out_idx, w_addr, b_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b w=%b b=%b ov=%b done=%b data=%0d idx=%0d want all 0",
               busy, w_rd_en, b_rd_en, out_valid, done, out_data, out_idx);
    end
    reset = 1'b1;
  endtask

  task automatic test_abort();
    bit saw_done;
    bit saw_valid;
    for (int i = 0; i < IN_N; i++) acts[i] = 8'sd64;
    for (int a = 0; a < IN_N*OUT_N; a++) wmem[a] = 8'sd1;
    for (int n = 0; n < OUT_N; n++) bmem[n] = 16'sd0;
    @(negedge clk); pack_acts(); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || w_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre busy=%b w_rd_en=%b want 1 1", busy, w_rd_en);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || w_rd_en !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_now busy=%b w_rd_en=%b out_valid=%b want 0 0 0",
               busy, w_rd_en, out_valid);
    end
    reset = 1'b1;
    saw_done = 1'b0; saw_valid = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (out_valid) saw_valid = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || saw_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_after done_seen=%b valid_seen=%b want 0 0", saw_done, saw_valid);
    end
  endtask

  task automatic test_uniform();
    for (int i = 0; i < IN_N; i++) acts[i] = 8'sd64;
    for (int a = 0; a < IN_N*OUT_N; a++) wmem[a] = 8'sd1;
    for (int n = 0; n < OUT_N; n++) bmem[n] = 16'sd0;
    run_layer(-1, 0, 1'b0, 3);
    end_of_run_checks("uniform");
    checks++;
    if (first_valid !== 18 || done_cyc !== 18*OUT_N + 1) begin
      errors++;
      $display("FAIL uniform_timing first=%0d done_at=%0d want 18 %0d",
               first_valid, done_cyc, 18*OUT_N + 1);
    end
  endtask

  task automatic test_round_bias();
    acts[0] = 8'sd32;
    for (int i = 1; i < IN_N; i++) acts[i] = 8'($urandom_range(0, 255));
    for (int a = 0; a < IN_N*OUT_N; a++) wmem[a] = (a % IN_N == 0) ? 8'sd3 : 8'sd0;
    for (int n = 0; n < OUT_N; n++) bmem[n] = (n % 2 == 1) ? -16'sd200 : 16'sd0;
    run_layer(-1, 0, 1'b0, 2);
    end_of_run_checks("round_bias");
  endtask

  task automatic test_saturate();
    for (int i = 0; i < IN_N; i++) acts[i] = 8'sd127;
    for (int n = 0; n < OUT_N; n++) begin
      for (int i = 0; i < IN_N; i++) wmem[n*IN_N+i] = (n % 2 == 0) ? 8'sd127 : -8'sd1;
      bmem[n] = 16'sd0;
    end
    run_layer(-1, 0, 1'b0, 2);
    end_of_run_checks("sat_a");
    for (int i = 0; i < IN_N; i++) acts[i] = 8'sd10;
    for (int n = 0; n < OUT_N; n++) begin
      for (int i = 0; i < IN_N; i++) wmem[n*IN_N+i] = (n % 3 == 0) ? -8'sd1 : 8'sd0;
      bmem[n] = (n % 3 == 1) ? 16'sd8160 : (n % 3 == 2) ? 16'sd8095 : 16'sd0;
    end
    run_layer(-1, 0, 1'b0, 2);
    end_of_run_checks("sat_b");
  endtask

  task automatic test_stall();
    for (int i = 0; i < IN_N; i++) acts[i] = 8'($urandom_range(0, 255));
    for (int a = 0; a < IN_N*OUT_N; a++) wmem[a] = 8'($urandom_range(0, 255));
    for (int n = 0; n < OUT_N; n++) bmem[n] = 16'($urandom_range(0, 4000)) - 16'sd2000;
    run_layer(3, 5, 1'b0, 2);
    end_of_run_checks("stall");
    checks++;
    if (done_cyc !== 18*OUT_N + 1 + 5) begin
      errors++;
      $display("FAIL stall_timing done_at=%0d want %0d", done_cyc, 18*OUT_N + 6);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < IN_N; i++) acts[i] = 8'($urandom_range(0, 127));
    for (int a = 0; a < IN_N*OUT_N; a++) wmem[a] = 8'($urandom_range(0, 255));
    for (int n = 0; n < OUT_N; n++) bmem[n] = 16'($urandom_range(0, 3000));
    run_layer(-1, 0, 1'b1, 4);
    end_of_run_checks("stray_start");
    run_layer(-1, 0, 1'b0, 0);
    end_of_run_checks("b2b_first");
    for (int i = 0; i < IN_N; i++) acts[i] = 8'($urandom_range(0, 127));
    run_layer(-1, 0, 1'b0, 2);
    end_of_run_checks("b2b_second");
    checks++;
    if (first_valid !== 18) begin
      errors++;
      $display("FAIL b2b_latency first=%0d want 18", first_valid);
    end
  endtask

  initial begin
    test_reset();
    test_abort();
    test_uniform();
    test_round_bias();
    test_saturate();
    test_stall();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
